spi_reg_rx: RTL
===============

SPI_REG_RX -- requirements
Module: spi_reg_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flop depth for i_sclk, i_mosi and i_ss_n; legal range 2..3.
REQ-002 Port clk, input, 1: system/pixel clock; all logic is on its rising edge.
REQ-003 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 Port i_sclk, input, 1: SPI clock, asynchronous to clk, mode 0 (sample on rising edge).
REQ-005 Port i_mosi, input, 1: SPI data, MSB first.
REQ-006 Port i_ss_n, input, 1: SPI slave select, active-low, frames one transaction.
REQ-007 Port i_frame_tick, input, 1: one-clk pulse at the start of vertical blanking from the video timing stage.
REQ-008 Port o_px, output, 16: live register 0, player X (Q8.8).
REQ-009 Port o_py, output, 16: live register 1, player Y (Q8.8).
REQ-010 Port o_fx, output, 16: live register 2, facing X (Q8.8, signed).
REQ-011 Port o_fy, output, 16: live register 3, facing Y (Q8.8, signed).
REQ-012 Port o_busy, output, 1: synchronized i_ss_n is low.
REQ-013 Port o_err, output, 1: one-clk pulse marking a rejected transaction.

Function
REQ-014 Each SPI input shall pass through a SYNC_STAGES flop chain before any use; no raw SPI input shall reach other logic.
REQ-015 A synchronized i_ss_n falling edge shall clear the 24-bit shift register and the 5-bit bit counter.
REQ-016 Each synchronized i_sclk rising edge while synchronized i_ss_n is low shall shift synchronized i_mosi into bit 0, MSB first.
REQ-017 On the same event, the bit counter shall increment and saturate at 25.
REQ-018 Transaction format, 24 bits: cmd[7:0], then data[15:0]; cmd[7:2] must be 0 and cmd[1:0] selects register 0..3.
REQ-019 A synchronized i_ss_n rising edge with count==24 and cmd[7:2]==0 shall commit data to the pending register selected by cmd[1:0] on the next clk edge.
REQ-020 A synchronized i_ss_n rising edge with any other count or cmd value shall not commit and shall pulse o_err for exactly one clk.
REQ-021 An i_sclk edge while synchronized i_ss_n is high shall be ignored.
REQ-022 A new transaction shall start with a fresh count regardless of any prior abort.
REQ-023 i_frame_tick shall copy all four pending registers to o_px/o_py/o_fx/o_fy on the next clk edge, so outputs change only at frame boundaries.
REQ-024 When a commit and i_frame_tick occur in the same cycle, the live outputs shall take the old pending values; the new value lands in pending and goes live at the following tick.
REQ-025 Latency from a physical i_sclk rise to the shift-register update shall be SYNC_STAGES+1 clk.
REQ-026 Correct operation requires clk >= 4x i_sclk; below that ratio, behaviour is undefined.

Reset
REQ-027 While rst_n is low at a clk edge: synchronizers idle (ss_n=1, sclk=0, mosi=0), shift register and counter 0, o_busy=0, o_err=0.
REQ-028 Reset values for pending and live registers: o_px=16'h0180, o_py=16'h0180, o_fx=16'h0100, o_fy=16'h0000.
REQ-029 Reset asserted mid-transaction shall discard the partial transaction; a later i_ss_n rise alone shall not raise o_err.

Configuration
REQ-030 Macro SPI_DOUBLE_BUFFER_EN defined: the pending/live double buffering of REQ-023..024 applies.
REQ-031 Macro SPI_DOUBLE_BUFFER_EN undefined: the pending registers are absent, a commit writes the live output directly on the clk edge after the synchronized ss_n rise, and i_frame_tick is ignored.

Structure
REQ-032 A shared package rbz_spi_pkg shall hold: command width 8, data width 16, frame length 24, register index constants REG_PX=0, REG_PY=1, REG_FX=2, REG_FY=3, and the four reset constants.
REQ-033 One sub-module, rbz_sync (parameterised depth, 1-bit synchronizer), shall be instantiated three times.
REQ-034 The shift, count and commit logic shall reside in spi_reg_rx itself.

Verification
REQ-035 Reset, no stimulus: outputs are 0180/0180/0100/0000, o_busy=0, o_err=0.
REQ-036 Send cmd 8'h00, data 16'h1234 at a 1:8 clk ratio, then pulse i_frame_tick: o_px=16'h1234 one clk after the tick and unchanged before it; no o_err.
REQ-037 Send 23 bits then raise ss_n: o_err pulses once, all registers are unchanged; the next valid cmd 8'h03, data 16'hFF00 with a tick gives o_fy=16'hFF00.
REQ-038 Send cmd 8'h84 with a valid 24-bit length: o_err pulses once and there is no commit; send 25 bits: o_err pulses once.
REQ-039 Commit cmd 8'h01, data 16'h0AAA in the same cycle as i_frame_tick: o_py stays 16'h0180, then becomes 16'h0AAA after the next tick.
REQ-040 Build without SPI_DOUBLE_BUFFER_EN and send cmd 8'h02, data 16'hFE00: o_fx=16'hFE00 without any tick; also assert rst_n low mid-transaction and confirm no o_err and reset values are restored.

Source files
------------

// File: rtl/rbz_spi_pkg.sv
// Shared constants for the SPI register receiver: frame geometry, register indices, reset values.
// Latency: none (constants only).  Backpressure: none.
package rbz_spi_pkg;

    localparam int CMD_W     = 8;
    localparam int DATA_W    = 16;
    localparam int FRAME_LEN = CMD_W + DATA_W;
    localparam int CNT_W     = 5;
    localparam logic [CNT_W-1:0] CNT_SAT = 5'd25;

    localparam logic [1:0] REG_PX = 2'd0;
    localparam logic [1:0] REG_PY = 2'd1;
    localparam logic [1:0] REG_FX = 2'd2;
    localparam logic [1:0] REG_FY = 2'd3;

    localparam logic [DATA_W-1:0] RST_PX = 16'h0180;
    localparam logic [DATA_W-1:0] RST_PY = 16'h0180;
    localparam logic [DATA_W-1:0] RST_FX = 16'h0100;
    localparam logic [DATA_W-1:0] RST_FY = 16'h0000;

endpackage

// File: rtl/rbz_sync.sv
// 1-bit multi-flop synchronizer with a configurable idle (reset) level.
// Latency: STAGES clk.  Backpressure: none, samples every cycle.
module rbz_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_reg_rx.sv
// SPI mode-0 slave writing four 16-bit registers; SPI_DOUBLE_BUFFER_EN adds frame-tick double buffering.
// Latency: sclk rise -> shift update SYNC_STAGES+1 clk; ss_n rise -> commit/o_err SYNC_STAGES+1 clk.
// Backpressure: none; requires clk >= 4x sclk, malformed frames are dropped with an o_err pulse.
module spi_reg_rx
    import rbz_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_sclk,
    input  logic              i_mosi,
    input  logic              i_ss_n,
    input  logic              i_frame_tick,
    output logic [DATA_W-1:0] o_px,
    output logic [DATA_W-1:0] o_py,
    output logic [DATA_W-1:0] o_fx,
    output logic [DATA_W-1:0] o_fy,
    output logic              o_busy,
    output logic              o_err
);

    logic                 sclk_s, mosi_s, ss_s;
    logic                 sclk_q, ss_q;
    logic [SYNC_STAGES:0] flush;
    logic                 armed;
    logic [FRAME_LEN-1:0] shreg;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_W-1:0]    live [4];

    logic ready, sclk_rise, ss_fall, ss_rise, frame_ok, commit;
    logic [1:0]        sel;
    logic [DATA_W-1:0] data;

    rbz_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(i_sclk), .q(sclk_s));
    rbz_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(i_mosi), .q(mosi_s));
    rbz_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst_n(rst_n), .d(i_ss_n), .q(ss_s));

    // Edges are ignored until the chain holds real pin samples, so a slave
    // select still low across reset cannot fake a falling edge and arm a frame.
    assign ready     = flush[SYNC_STAGES];
    assign sclk_rise = sclk_s & ~sclk_q;
    assign ss_fall   = ready & ss_q & ~ss_s;
    assign ss_rise   = ready & ~ss_q & ss_s;
    assign sel       = shreg[DATA_W+1:DATA_W];
    assign data      = shreg[DATA_W-1:0];
    assign frame_ok  = (cnt == CNT_W'(FRAME_LEN)) && (shreg[FRAME_LEN-1:DATA_W+2] == '0);
    assign commit    = ss_rise & armed & frame_ok;
    assign o_busy    = ~ss_s;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q <= 1'b0;
            ss_q   <= 1'b1;
            flush  <= '0;
            armed  <= 1'b0;
            shreg  <= '0;
            cnt    <= '0;
            o_err  <= 1'b0;
        end else begin
            sclk_q <= sclk_s;
            ss_q   <= ss_s;
            flush  <= {flush[SYNC_STAGES-1:0], 1'b1};
            o_err  <= ss_rise & armed & ~frame_ok;
            if (ss_fall) begin
                armed <= 1'b1;
            end else if (ss_rise) begin
                armed <= 1'b0;
            end
            if (ss_fall) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (sclk_rise && !ss_s) begin
                shreg <= {shreg[FRAME_LEN-2:0], mosi_s};
                cnt   <= (cnt == CNT_SAT) ? CNT_SAT : cnt + 1'b1;
            end
        end
    end

`ifdef SPI_DOUBLE_BUFFER_EN
    logic [DATA_W-1:0] pend [4];

    // Tick and commit in one cycle: live takes the old pending value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend[REG_PX] <= RST_PX;
            pend[REG_PY] <= RST_PY;
            pend[REG_FX] <= RST_FX;
            pend[REG_FY] <= RST_FY;
            live[REG_PX] <= RST_PX;
            live[REG_PY] <= RST_PY;
            live[REG_FX] <= RST_FX;
            live[REG_FY] <= RST_FY;
        end else begin
            if (i_frame_tick) begin
                live <= pend;
            end
            if (commit) begin
                pend[sel] <= data;
            end
        end
    end
`else
    logic unused_frame_tick;
    assign unused_frame_tick = i_frame_tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live[REG_PX] <= RST_PX;
            live[REG_PY] <= RST_PY;
            live[REG_FX] <= RST_FX;
            live[REG_FY] <= RST_FY;
        end else if (commit) begin
            live[sel] <= data;
        end
    end
`endif

    assign o_px = live[REG_PX];
    assign o_py = live[REG_PY];
    assign o_fx = live[REG_FX];
    assign o_fy = live[REG_FY];

endmodule
